// File: rtl/shift_serializer.sv
// 4-bit word serializer: start bit, 4 data bits (LSB or MSB first), stop bit.
// Optional even-parity bit is enabled by defining SHIFT_SERIALIZER_PARITY_EN.
module shift_serializer #(
    parameter int BAUD_DIV = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_data,
    input  logic       dir,
    output logic       ser_out,
    output logic       busy,
    output logic       done
);

`ifdef SHIFT_SERIALIZER_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    localparam logic [3:0] LAST = 4'(BAUD_DIV - 1);
    localparam logic [3:0] PRE  = 4'(BAUD_DIV - 2);
    localparam bit         ONE  = (BAUD_DIV == 1);

    state_t     state;
    logic [3:0] cnt;
    logic [3:0] sreg;
    logic [1:0] bit_idx;
    logic       order;
    logic       last;
    logic       pre_last;

`ifdef SHIFT_SERIALIZER_PARITY_EN
    logic       par;
`endif

    assign last     = (cnt == LAST);
    // done must rise one cycle before the final STOP cycle ends
    assign pre_last = !ONE && (cnt == PRE);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            cnt      <= '0;
            sreg     <= '0;
            bit_idx  <= '0;
            order    <= 1'b0;
            ser_out  <= 1'b1;
            in_ready <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
`ifdef SHIFT_SERIALIZER_PARITY_EN
            par      <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    ser_out  <= 1'b1;
                    in_ready <= 1'b1;
                    busy     <= 1'b0;
                    done     <= 1'b0;
                    cnt      <= '0;
                    if (in_valid) begin
                        sreg     <= in_data;
                        order    <= dir;
`ifdef SHIFT_SERIALIZER_PARITY_EN
                        par      <= ^in_data;
`endif
                        state    <= START;
                        ser_out  <= 1'b0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                START: begin
                    if (last) begin
                        state   <= DATA;
                        cnt     <= '0;
                        bit_idx <= '0;
                        ser_out <= order ? sreg[3] : sreg[0];
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                DATA: begin
                    if (last) begin
                        cnt  <= '0;
                        sreg <= order ? {sreg[2:0], 1'b0}
                                      : {1'b0, sreg[3:1]};
                        if (bit_idx == 2'd3) begin
`ifdef SHIFT_SERIALIZER_PARITY_EN
                            state   <= PARITY;
                            ser_out <= par;
`else
                            state   <= STOP;
                            ser_out <= 1'b1;
                            done    <= ONE;
`endif
                        end else begin
                            bit_idx <= bit_idx + 2'd1;
                            ser_out <= order ? sreg[2] : sreg[1];
                        end
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
`ifdef SHIFT_SERIALIZER_PARITY_EN
                PARITY: begin
                    if (last) begin
                        state   <= STOP;
                        cnt     <= '0;
                        ser_out <= 1'b1;
                        done    <= ONE;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
`endif
                STOP: begin
                    if (last) begin
                        state    <= IDLE;
                        cnt      <= '0;
                        ser_out  <= 1'b1;
                        in_ready <= 1'b1;
                        busy     <= 1'b0;
                        done     <= 1'b0;
                    end else begin
                        cnt  <= cnt + 4'd1;
                        done <= pre_last;
                    end
                end
                default: begin
                    state    <= IDLE;
                    cnt      <= '0;
                    ser_out  <= 1'b1;
                    in_ready <= 1'b1;
                    busy     <= 1'b0;
                    done     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_serializer.sv
// Bench for shift_serializer: BAUD_DIV=2 instance for frames and reset,
// BAUD_DIV=1 instance for back-to-back words.
module tb_shift_serializer;

    logic       clk = 1'b0;
    logic       reset;
    logic       a_valid, a_ready, a_dir, a_ser, a_busy, a_done;
    logic [3:0] a_data;
    logic       b_valid, b_ready, b_dir, b_ser, b_busy, b_done;
    logic [3:0] b_data;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic ser;
        logic done;
        logic busy;
    } exp_t;

    typedef struct {
        logic [3:0] data;
        logic       dir;
        logic [3:0] bits;
    } vec_t;

    exp_t q[$];

    always #5 clk = ~clk;

    shift_serializer #(.BAUD_DIV(2)) dut_a (
        .clk(clk), .reset(reset), .in_valid(a_valid), .in_ready(a_ready),
        .in_data(a_data), .dir(a_dir), .ser_out(a_ser), .busy(a_busy),
        .done(a_done)
    );

    shift_serializer #(.BAUD_DIV(1)) dut_b (
        .clk(clk), .reset(reset), .in_valid(b_valid), .in_ready(b_ready),
        .in_data(b_data), .dir(b_dir), .ser_out(b_ser), .busy(b_busy),
        .done(b_done)
    );

    task automatic chk(input string name, input logic [3:0] got,
                       input logic [3:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b at %0t", name, got, exp,
                     $time);
        end
    endtask

    // Expected frame; bits is the data bit sequence, first-emitted in [3].
    task automatic push_frame(input logic [3:0] d, input logic [3:0] bits,
                              input int div);
        exp_t e;
        for (int i = 0; i < div; i++) begin
            e = '{ser: 1'b0, done: 1'b0, busy: 1'b1};
            q.push_back(e);
        end
        for (int k = 3; k >= 0; k--)
            for (int i = 0; i < div; i++) begin
                e = '{ser: bits[k], done: 1'b0, busy: 1'b1};
                q.push_back(e);
            end
`ifdef SHIFT_SERIALIZER_PARITY_EN
        for (int i = 0; i < div; i++) begin
            e = '{ser: ^d, done: 1'b0, busy: 1'b1};
            q.push_back(e);
        end
`else
        if (d == 4'hx) $display("unknown data");
`endif
        for (int i = 0; i < div; i++) begin
            e = '{ser: 1'b1, done: (i == div - 1), busy: 1'b1};
            q.push_back(e);
        end
    endtask

    task automatic check_a(input string tag, input exp_t e);
        chk({tag, ".ser"}, {3'b0, a_ser}, {3'b0, e.ser});
        chk({tag, ".done"}, {3'b0, a_done}, {3'b0, e.done});
        chk({tag, ".busy"}, {2'b0, a_busy, a_ready}, {2'b0, e.busy, !e.busy});
    endtask

    task automatic check_b(input string tag, input exp_t e);
        chk({tag, ".ser"}, {3'b0, b_ser}, {3'b0, e.ser});
        chk({tag, ".done"}, {3'b0, b_done}, {3'b0, e.done});
        chk({tag, ".busy"}, {2'b0, b_busy, b_ready}, {2'b0, e.busy, !e.busy});
    endtask

    task automatic idle_a(input string tag);
        exp_t e;
        e = '{ser: 1'b1, done: 1'b0, busy: 1'b0};
        check_a(tag, e);
    endtask

    // Sends one word on A and checks it cycle by cycle while scrambling inputs.
    task automatic frame_a(input vec_t v);
        exp_t e;
        q.delete();
        push_frame(v.data, v.bits, 2);
        a_valid = 1'b1;
        a_data  = v.data;
        a_dir   = v.dir;
        @(posedge clk);
        while (q.size() > 0) begin
            @(negedge clk);
            a_valid = 1'b0;
            a_data  = 4'($urandom);
            a_dir   = 1'($urandom);
            e = q.pop_front();
            check_a($sformatf("frame_%b_%b", v.data, v.dir), e);
        end
        @(negedge clk);
        idle_a("post_frame_idle");
    endtask

    vec_t vecs[7];

    initial begin
        exp_t e;
        int   len;

        vecs[0] = '{data: 4'b1010, dir: 1'b0, bits: 4'b0101};
        vecs[1] = '{data: 4'b1010, dir: 1'b1, bits: 4'b1010};
        vecs[2] = '{data: 4'b1111, dir: 1'b0, bits: 4'b1111};
        vecs[3] = '{data: 4'b0001, dir: 1'b0, bits: 4'b1000};
        vecs[4] = '{data: 4'b0001, dir: 1'b1, bits: 4'b0001};
        vecs[5] = '{data: 4'b1011, dir: 1'b0, bits: 4'b1101};
        vecs[6] = '{data: 4'b0110, dir: 1'b1, bits: 4'b0110};

        reset   = 1'b0;
        a_valid = 1'b0; a_data = '0; a_dir = 1'b0;
        b_valid = 1'b0; b_data = '0; b_dir = 1'b0;
        repeat (2) @(negedge clk);
        idle_a("reset_a");
        e = '{ser: 1'b1, done: 1'b0, busy: 1'b0};
        check_b("reset_b", e);
        reset = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) frame_a(vecs[i]);

        // Reset held 3 cycles in the middle of a frame
        a_valid = 1'b1; a_data = 4'b1111; a_dir = 1'b0;
        @(posedge clk);
        @(negedge clk);
        a_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("mid_frame_busy", {3'b0, a_busy}, 4'd1);
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            idle_a("reset_mid");
        end
        reset = 1'b1;
        repeat (14) begin
            @(negedge clk);
            idle_a("after_reset_no_done");
        end
        frame_a(vecs[0]);

        // Reset wins over a simultaneous handshake
        reset = 1'b0; a_valid = 1'b1; a_data = 4'b1111;
        @(negedge clk);
        idle_a("reset_vs_valid");
        reset = 1'b1; a_valid = 1'b0;
        @(negedge clk);
        idle_a("reset_vs_valid_after");

        // Back-to-back words on the BAUD_DIV=1 instance, in_valid held high
        q.delete();
        push_frame(4'b1010, 4'b0101, 1);
        len = q.size();
        e = '{ser: 1'b1, done: 1'b0, busy: 1'b0};
        q.push_back(e);
        push_frame(4'b0011, 4'b0011, 1);
        b_valid = 1'b1; b_data = 4'b1010; b_dir = 1'b0;
        @(posedge clk);
        for (int idx = 0; q.size() > 0; idx++) begin
            @(negedge clk);
            if (idx == 0) begin
                b_data = 4'b0011;
                b_dir  = 1'b1;
            end
            if (idx == len + 1) begin
                b_valid = 1'b0;
                b_data  = 4'($urandom);
            end
            e = q.pop_front();
            check_b($sformatf("b2b_%0d", idx), e);
        end
        @(negedge clk);
        e = '{ser: 1'b1, done: 1'b0, busy: 1'b0};
        check_b("b2b_idle", e);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
